// File: rtl/sdram_arbiter.sv
// Arbiter sharing one 8-bit SDRAM port between the ROM loader (writes) and the renderer (reads).
// Define SDRAM_ARB_RR_EN for round-robin selection; otherwise the loader always wins.
module sdram_arbiter #(
    parameter int AW      = 25,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ld_wr,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic          ld_wait,
    output logic          ld_ovf,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_base,
    input  logic [AW-1:0] rd_off,
    output logic          rd_busy,
    output logic          rd_valid,
    output logic [7:0]    rd_data,
    output logic [AW-1:0] sdram_addr,
    output logic [7:0]    sdram_din,
    output logic          sdram_rd,
    output logic          sdram_we,
    input  logic          sdram_ack,
    input  logic [7:0]    sdram_dout,
    output logic          timeout_err,
    output logic [1:0]    dbg_state
);

    // Strobe protocol: ld_wr/rd_req are single-cycle requests accepted only when the
    // matching buffer is free (ld_wait/rd_busy low); sdram_we/sdram_rd pulse once per
    // command and sdram_ack is honoured only while an operation is in WAIT.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [9:0] TO = TIMEOUT[9:0];

    state_t        r_state;
    state_t        w_next;
    logic          r_ld_full;
    logic          r_ld_ovf;
    logic [AW-1:0] r_ld_addr;
    logic [7:0]    r_ld_data;
    logic          r_rd_busy;
    logic [AW-1:0] r_rd_addr;
    logic          r_op_wr;
    logic [AW-1:0] r_sdram_addr;
    logic [7:0]    r_sdram_din;
    logic [9:0]    r_wdog;
    logic          r_rd_valid;
    logic [7:0]    r_rd_data;
    logic          r_timeout_err;
    logic          w_select;
    logic          w_grant_wr;
    logic          w_done;
    logic          w_expired;
    logic          w_wr_prio;

`ifdef SDRAM_ARB_RR_EN
    logic r_last_wr;

    // Resets to "renderer served last" so the loader wins the first tie.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_last_wr <= 1'b0;
        end else if (w_select) begin
            r_last_wr <= w_grant_wr;
        end
    end

    assign w_wr_prio = ~r_last_wr;
`else
    assign w_wr_prio = 1'b1;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_select   = 1'b0;
        w_grant_wr = 1'b0;
        w_done     = 1'b0;
        w_expired  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_ld_full || r_rd_busy) begin
                    w_select   = 1'b1;
                    w_grant_wr = r_ld_full & (w_wr_prio | ~r_rd_busy);
                    w_next     = ISSUE;
                end
            end
            ISSUE: w_next = WAIT;
            WAIT: begin
                w_expired = ~sdram_ack & ((r_wdog + 10'd1) == TO);
                w_done    = sdram_ack | w_expired;
                if (w_done) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_ld_full     <= 1'b0;
            r_ld_ovf      <= 1'b0;
            r_ld_addr     <= '0;
            r_ld_data     <= 8'h00;
            r_rd_busy     <= 1'b0;
            r_rd_addr     <= '0;
            r_op_wr       <= 1'b0;
            r_sdram_addr  <= '0;
            r_sdram_din   <= 8'h00;
            r_wdog        <= 10'd0;
            r_rd_valid    <= 1'b0;
            r_rd_data     <= 8'h00;
            r_timeout_err <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            if (ld_wr) begin
                if (r_ld_full) begin
                    r_ld_ovf <= 1'b1;
                end else begin
                    r_ld_full <= 1'b1;
                    r_ld_addr <= ld_addr;
                    r_ld_data <= ld_data;
                end
            end
            if (rd_req && !r_rd_busy) begin
                r_rd_busy <= 1'b1;
                r_rd_addr <= rd_base + rd_off;
            end
            if (w_select) begin
                r_op_wr      <= w_grant_wr;
                r_sdram_addr <= w_grant_wr ? r_ld_addr : r_rd_addr;
                if (w_grant_wr) begin
                    r_sdram_din <= r_ld_data;
                end
            end
            if (r_state == ISSUE) begin
                r_wdog <= 10'd0;
            end else if (r_state == WAIT) begin
                r_wdog <= r_wdog + 10'd1;
            end
            // A watchdog expiry completes the operation exactly like an ack, with zero read data.
            if (w_done) begin
                if (w_expired) begin
                    r_timeout_err <= 1'b1;
                end
                if (r_op_wr) begin
                    r_ld_full <= 1'b0;
                end else begin
                    r_rd_busy  <= 1'b0;
                    r_rd_valid <= 1'b1;
                    r_rd_data  <= w_expired ? 8'h00 : sdram_dout;
                end
            end
        end
    end

    assign ld_wait     = r_ld_full;
    assign ld_ovf      = r_ld_ovf;
    assign rd_busy     = r_rd_busy;
    assign rd_valid    = r_rd_valid;
    assign rd_data     = r_rd_data;
    assign sdram_addr  = r_sdram_addr;
    assign sdram_din   = r_sdram_din;
    assign sdram_we    = (r_state == ISSUE) & r_op_wr;
    assign sdram_rd    = (r_state == ISSUE) & ~r_op_wr;
    assign timeout_err = r_timeout_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: commands and read results are checked from expected queues.
module tb_sdram_arbiter;
  localparam int AW = 25;
  localparam int W  = AW + 9;

  logic          clk_sys = 1'b0;
  logic          reset   = 1'b1;
  logic          ld_wr   = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [7:0]    ld_data = 8'h00;
  logic          ld_wait;
  logic          ld_ovf;
  logic          rd_req  = 1'b0;
  logic [AW-1:0] rd_base = '0;
  logic [AW-1:0] rd_off  = '0;
  logic          rd_busy;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic [AW-1:0] sdram_addr;
  logic [7:0]    sdram_din;
  logic          sdram_rd;
  logic          sdram_we;
  logic          sdram_ack;
  logic [7:0]    sdram_dout = 8'h00;
  logic          timeout_err;
  logic [1:0]    dbg_state;

  logic          resp_ack  = 1'b0;
  logic          man_ack   = 1'b0;
  logic [7:0]    ack_data  = 8'h00;
  int            pend      = 0;
  int            ack_delay = 4;
  bit            ack_en    = 1'b1;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   exp_rd_q[$];

  assign sdram_ack = resp_ack | man_ack;

  sdram_arbiter #(.AW(AW), .TIMEOUT(8)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ld_wr       (ld_wr),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_wait     (ld_wait),
    .ld_ovf      (ld_ovf),
    .rd_req      (rd_req),
    .rd_base     (rd_base),
    .rd_off      (rd_off),
    .rd_busy     (rd_busy),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .sdram_addr  (sdram_addr),
    .sdram_din   (sdram_din),
    .sdram_rd    (sdram_rd),
    .sdram_we    (sdram_we),
    .sdram_ack   (sdram_ack),
    .sdram_dout  (sdram_dout),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  // SDRAM responder: ack arrives ack_delay cycles after the command cycle
  always @(posedge clk_sys) begin
    #2;
    resp_ack   = 1'b0;
    sdram_dout = ack_data;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) resp_ack = 1'b1;
    end else if ((sdram_we || sdram_rd) && ack_en) begin
      pend = ack_delay;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk_sys) begin
    if (sdram_we || sdram_rd) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_cmd: got we=%0b rd=%0b addr=%0h expected none", sdram_we, sdram_rd, sdram_addr);
      end else begin
        check("sdram_cmd", {sdram_we, sdram_addr, (sdram_we ? sdram_din : 8'h00)}, exp_q.pop_front());
      end
    end
    if (rd_valid) begin
      if (exp_rd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rd_valid: got data=%0h expected none", rd_data);
      end else begin
        check("rd_data", rd_data, exp_rd_q.pop_front());
      end
    end
  end

  function automatic logic [63:0] all_outs();
    return {ld_wait, ld_ovf, rd_busy, rd_valid, rd_data, sdram_addr, sdram_din,
            sdram_rd, sdram_we, timeout_err, dbg_state};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [7:0] d);
    exp_q.push_back({1'b1, a, d});
  endtask

  task automatic push_rd(input logic [AW-1:0] a, input logic [7:0] d);
    exp_q.push_back({1'b0, a, 8'h00});
    exp_rd_q.push_back(d);
  endtask

  task automatic ld_write(input logic [AW-1:0] a, input logic [7:0] d);
    step();
    ld_wr = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_wr = 1'b0;
  endtask

  task automatic rd_read(input logic [AW-1:0] b, input logic [AW-1:0] o);
    step();
    rd_req = 1'b1;
    rd_base = b;
    rd_off = o;
    step();
    rd_req = 1'b0;
  endtask

  task automatic wait_ack(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_sys);
      if (sdram_ack) seen = 1'b1;
    end
    check(name, seen, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    bit idle = 1'b0;
    for (int i = 0; i < 80 && !idle; i++) begin
      @(negedge clk_sys);
      if (!ld_wait && !rd_busy && dbg_state == 2'd0) idle = 1'b1;
    end
    check(name, idle, 1'b1);
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bit seen;
    int n;

    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("reset_outputs", all_outs(), 64'h0);
    step();
    reset = 1'b0;

    // single write, ack 4 cycles after sdram_we
    ack_delay = 4;
    push_wr(25'h000010, 8'hA5);
    ld_write(25'h000010, 8'hA5);
    @(negedge clk_sys);
    check("wr_ld_wait_t1", ld_wait, 1'b1);
    check("wr_no_we_t1", sdram_we, 1'b0);
    @(negedge clk_sys);
    check("wr_we_t2", sdram_we, 1'b1);
    wait_ack("wr_ack_seen");
    check("wr_ld_wait_at_ack", ld_wait, 1'b1);
    @(negedge clk_sys);
    check("wr_ld_wait_after_ack", ld_wait, 1'b0);

    // read with address wrap
    ack_data = 8'h3C;
    push_rd(25'h0000001, 8'h3C);
    rd_read(25'h1FFFFFF, 25'h0000002);
    @(negedge clk_sys);
    check("rd_busy_set", rd_busy, 1'b1);
    wait_ack("rd_ack_seen");
    check("rd_valid_not_at_ack", rd_valid, 1'b0);
    @(negedge clk_sys);
    check("rd_valid_after_ack", rd_valid, 1'b1);
    check("rd_busy_cleared", rd_busy, 1'b0);
    @(negedge clk_sys);
    check("rd_valid_one_cycle", rd_valid, 1'b0);
    check("rd_data_held", rd_data, 8'h3C);

    // contention pair A: loader served first in both builds
    ack_data = 8'h5A;
    push_wr(25'h000123, 8'h77);
    push_rd(25'h000120, 8'h5A);
    step();
    ld_wr = 1'b1; ld_addr = 25'h000123; ld_data = 8'h77;
    rd_req = 1'b1; rd_base = 25'h000100; rd_off = 25'h000020;
    step();
    ld_wr = 1'b0; rd_req = 1'b0;
    wait_idle("pair_a_idle");

    // lone write leaves the loader as last served
    push_wr(25'h000300, 8'h01);
    ld_write(25'h000300, 8'h01);
    wait_idle("lone_wr_idle");

    // contention pair B
    ack_data = 8'h6B;
`ifdef SDRAM_ARB_RR_EN
    push_rd(25'h000410, 8'h6B);
    push_wr(25'h000301, 8'h02);
`else
    push_wr(25'h000301, 8'h02);
    push_rd(25'h000410, 8'h6B);
`endif
    step();
    ld_wr = 1'b1; ld_addr = 25'h000301; ld_data = 8'h02;
    rd_req = 1'b1; rd_base = 25'h000400; rd_off = 25'h000010;
    step();
    ld_wr = 1'b0; rd_req = 1'b0;
    wait_idle("pair_b_idle");

    // overflow: second byte dropped
    check("ovf_clear_before", ld_ovf, 1'b0);
    push_wr(25'h000200, 8'h11);
    step();
    ld_wr = 1'b1; ld_addr = 25'h000200; ld_data = 8'h11;
    step();
    ld_addr = 25'h000201; ld_data = 8'h22;
    step();
    ld_wr = 1'b0;
    @(negedge clk_sys);
    check("ovf_set", ld_ovf, 1'b1);
    check("ovf_ld_wait", ld_wait, 1'b1);
    wait_idle("ovf_idle");
    check("ovf_sticky", ld_ovf, 1'b1);

    // watchdog timeout on a read
    check("tmo_clear_before", timeout_err, 1'b0);
    ack_en = 1'b0;
    push_rd(25'h000045, 8'h00);
    rd_read(25'h000040, 25'h000005);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_sys);
      if (sdram_rd) seen = 1'b1;
    end
    check("tmo_cmd_seen", seen, 1'b1);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk_sys);
      n++;
      if (rd_valid) seen = 1'b1;
    end
    check("tmo_rd_valid_seen", seen, 1'b1);
    check("tmo_latency", n, 9);
    check("tmo_err_set", timeout_err, 1'b1);
    check("tmo_rd_data", rd_data, 8'h00);
    @(negedge clk_sys);
    check("tmo_back_idle", {rd_busy, dbg_state}, 3'b000);
    ack_data = 8'hEE;
    step();
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("late_ack_ignored", {rd_data, dbg_state, rd_busy}, {8'h00, 2'd0, 1'b0});
    ack_en = 1'b1;

    // reset during WAIT, then a stale ack
    ack_delay = 6;
    ack_data = 8'h99;
    exp_q.push_back({1'b0, 25'h000077, 8'h00});
    rd_read(25'h000000, 25'h000077);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_sys);
      if (sdram_rd) seen = 1'b1;
    end
    check("rst_cmd_seen", seen, 1'b1);
    repeat (2) @(negedge clk_sys);
    check("rst_in_wait", dbg_state, 2'd2);
    step();
    reset = 1'b1;
    @(negedge clk_sys);
    check("rst_mid_outputs", all_outs(), 64'h0);
    step();
    reset = 1'b0;
    repeat (8) @(negedge clk_sys);
    check("rst_stale_ack_outputs", all_outs(), 64'h0);

    check("exp_cmd_drained", exp_q.size(), 0);
    check("exp_rd_drained", exp_rd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
